// File: rtl/button_capture_if.sv
// Memory-bus slave interface for button_capture: address/select/strobes from the
// bus master, OR-combined read data and ready back from the slave.
`timescale 1ns/1ps
interface button_capture_if;
    logic [31:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic        ready_out;

    modport master (
        output address_in, sel_in, read_in, write_mask_in, write_value_in,
        input  read_value_out, ready_out
    );

    modport slave (
        input  address_in, sel_in, read_in, write_mask_in, write_value_in,
        output read_value_out, ready_out
    );
endinterface

// File: rtl/button_capture.sv
// button_capture: synchronises and debounces raw buttons, latches sticky press
// flags (W1C) and keeps a 16-bit wrapping press counter, all readable over a
// 16-byte bus window. Defining BUTTON_CAPTURE_RELEASE_EN adds sticky release
// flags in EVENTS[16 +: BUTTONCOUNT].
`timescale 1ns/1ps
module button_capture #(
    parameter int BUTTONCOUNT     = 4,
    parameter int DEBOUNCE_CYCLES = 36000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BUTTONCOUNT-1:0] buttons_in,
    button_capture_if.slave        bus,
    output logic                   event_pending_out
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value on the cycle that completes the stable window.
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [BUTTONCOUNT-1:0] level;
    logic [BUTTONCOUNT-1:0] rise;
    logic [BUTTONCOUNT-1:0] fall;

    logic [BUTTONCOUNT-1:0] press_flags_reg;
    logic [15:0]            count_reg;
    logic [15:0]            press_total;
    logic [31:0]            byte_mask;
    logic [31:0]            w1c_bits;
    logic                   count_clear;
    logic [15:0]            press_ext;
    logic [15:0]            release_ext;
    logic                   any_event;

    // Per-button synchroniser and debounce counter.
    generate
        for (genvar gi = 0; gi < BUTTONCOUNT; gi++) begin : g_button
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic [CW-1:0] cnt_reg;
            logic          accept;

            assign accept = (sync2_reg != level_reg) && (cnt_reg == LAST);

            // Two-flop sync, then count consecutive cycles the synced level differs.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= buttons_in[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != level_reg) begin
                        if (cnt_reg == LAST) begin
                            level_reg <= sync2_reg;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign level[gi] = level_reg;
            assign rise[gi]  = accept &  sync2_reg;
            assign fall[gi]  = accept & ~sync2_reg;
        end
    endgenerate

    assign byte_mask = {{8{bus.write_mask_in[3]}}, {8{bus.write_mask_in[2]}},
                        {8{bus.write_mask_in[1]}}, {8{bus.write_mask_in[0]}}};
    assign w1c_bits    = (bus.sel_in && bus.address_in[3:2] == 2'd1) ?
                         (bus.write_value_in & byte_mask) : 32'd0;
    assign count_clear = bus.sel_in && (bus.address_in[3:2] == 2'd2) && (|bus.write_mask_in);

    // Number of buttons whose debounced level rises this cycle.
    always_comb begin
        press_total = '0;
        for (int i = 0; i < BUTTONCOUNT; i++) begin
            press_total = press_total + 16'(rise[i]);
        end
    end

    // Press flags: W1C clears first, a new press in the same cycle wins.
    // COUNT: optional clear, then add this cycle's presses (wraps naturally).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_flags_reg <= '0;
            count_reg       <= '0;
        end else begin
            press_flags_reg <= (press_flags_reg & ~w1c_bits[BUTTONCOUNT-1:0]) | rise;
            count_reg       <= (count_clear ? 16'd0 : count_reg) + press_total;
        end
    end

    // Zero-extend press flags to the 16-bit half of EVENTS.
    always_comb begin
        press_ext = '0;
        press_ext[BUTTONCOUNT-1:0] = press_flags_reg;
    end

`ifdef BUTTON_CAPTURE_RELEASE_EN
    logic [BUTTONCOUNT-1:0] release_flags_reg;

    // Release flags follow the same clear-then-set rule as press flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            release_flags_reg <= '0;
        end else begin
            release_flags_reg <= (release_flags_reg & ~w1c_bits[16 +: BUTTONCOUNT]) | fall;
        end
    end

    // Zero-extend release flags to the upper half of EVENTS.
    always_comb begin
        release_ext = '0;
        release_ext[BUTTONCOUNT-1:0] = release_flags_reg;
    end
`else
    assign release_ext = '0;
`endif

    assign any_event = (|press_ext) | (|release_ext);

    // Pending status for a future interrupt line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_pending_out <= 1'b0;
        end else begin
            event_pending_out <= any_event;
        end
    end

    // Combinational read mux, gated by select so it can be OR-ed onto the bus.
    always_comb begin
        bus.read_value_out = '0;
        if (bus.sel_in) begin
            case (bus.address_in[3:2])
                2'd0:    bus.read_value_out[BUTTONCOUNT-1:0] = level;
                2'd1:    bus.read_value_out = {release_ext, press_ext};
                2'd2:    bus.read_value_out[15:0] = count_reg;
                default: bus.read_value_out = '0;
            endcase
        end
    end

    assign bus.ready_out = bus.sel_in;

    // Reads carry no side effects, and only address bits [3:2] are decoded.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.read_in, bus.address_in, bus.write_value_in, fall};
endmodule

// File: tb/tb_button_capture.sv
// Self-checking bench for button_capture (BUTTONCOUNT=4, DEBOUNCE_CYCLES=4).
// Expected register values come from a small behavioural model and are queued,
// then popped and compared as the bus reads return data.
`timescale 1ns/1ps
module tb_button_capture;
    localparam int BC = 4;
    localparam int D  = 4;
`ifdef BUTTON_CAPTURE_RELEASE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [BC-1:0] buttons = '0;
    logic          event_pending;

    button_capture_if bus ();

    button_capture #(.BUTTONCOUNT(BC), .DEBOUNCE_CYCLES(D)) dut (
        .clk               (clk),
        .reset             (reset),
        .buttons_in        (buttons),
        .bus               (bus.slave),
        .event_pending_out (event_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          checks = 0;
    int          fails  = 0;

    logic [BC-1:0] m_state  = '0;
    logic [31:0]   m_events = '0;
    logic [15:0]   m_count  = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] popcount(input logic [BC-1:0] v);
        logic [15:0] s = '0;
        for (int i = 0; i < BC; i++) s = s + 16'(v[i]);
        return s;
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    task automatic bus_read(input string tag, input logic [31:0] addr, output logic [31:0] data);
        bus.sel_in     = 1'b1;
        bus.read_in    = 1'b1;
        bus.address_in = addr;
        #2;
        data = bus.read_value_out;
        check({tag, "_rdy"}, 32'(bus.ready_out), 32'd1);
        bus.sel_in  = 1'b0;
        bus.read_in = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask, input logic sel);
        bus.sel_in         = sel;
        bus.address_in     = addr;
        bus.write_value_in = data;
        bus.write_mask_in  = mask;
        tick(1);
        bus.sel_in         = 1'b0;
        bus.write_value_in = '0;
        bus.write_mask_in  = '0;
    endtask

    task automatic push(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        sb_entry_t e;
        e.tag  = tag;
        e.addr = addr;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic push_regs(input string pfx);
        push({pfx, "_state"},  32'h0, 32'(m_state));
        push({pfx, "_events"}, 32'h4, m_events);
        push({pfx, "_count"},  32'h8, 32'(m_count));
    endtask

    task automatic drain();
        sb_entry_t   e;
        logic [31:0] v;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            bus_read(e.tag, e.addr, v);
            check(e.tag, v, e.exp);
        end
    endtask

    // Model the debounced effect of a new button level.
    task automatic model_levels(input logic [BC-1:0] nb);
        logic [BC-1:0] r;
        logic [BC-1:0] f;
        r = nb & ~m_state;
        f = m_state & ~nb;
        m_events = m_events | 32'(r);
        if (REL_EN) m_events = m_events | (32'(f) << 16);
        m_count = m_count + popcount(r);
        m_state = nb;
    endtask

    task automatic settle(input string pfx, input logic [BC-1:0] nb);
        buttons = nb;
        tick(2 + D);
        model_levels(nb);
        push_regs(pfx);
        drain();
        tick(1);
        check({pfx, "_pend"}, 32'(event_pending), 32'(|m_events));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        bus.sel_in = 1'b0; bus.read_in = 1'b0; bus.address_in = '0;
        bus.write_mask_in = '0; bus.write_value_in = '0;

        // Reset state
        tick(3);
        push_regs("rst");
        drain();
        check("rst_pend", 32'(event_pending), 32'd0);
        check("rst_ready_idle", 32'(bus.ready_out), 32'd0);
        reset = 1'b0;
        tick(2);

        // First press: latency 2 + D, pending one cycle after EVENTS
        buttons = 4'b0001;
        tick(5);
        bus_read("lat5", 32'h0, v); check("lat5_state", v, 32'h0);
        tick(1);
        bus_read("lat6", 32'h0, v); check("lat6_state", v, 32'h1);
        check("lat6_pend", 32'(event_pending), 32'd0);
        model_levels(4'b0001);
        push_regs("press0");
        drain();
        tick(1);
        check("press0_pend", 32'(event_pending), 32'd1);

        // Glitch of D-1 cycles on bit 1 is rejected
        buttons = 4'b0011;
        tick(D - 1);
        buttons = 4'b0001;
        tick(10);
        push_regs("glitch");
        drain();

        // Release button 0, then press button 1 -> press flags 0x3
        settle("rel0", 4'b0000);
        settle("press1", 4'b0010);

        // W1C with mask, then masked-off write
        bus_write(32'h4, 32'h1, 4'b0001, 1'b1);
        m_events = m_events & ~(32'h1 & expand(4'b0001));
        push_regs("w1c1");
        bus_write(32'h4, 32'h2, 4'b0000, 1'b1);
        push_regs("w1c_nomask");
        bus_write(32'h4, 32'hFFFF_FFFF, 4'hF, 1'b0);
        push_regs("w1c_nosel");
        drain();

        // Press of bit 2 lands in the same cycle as W1C of bits 1 and 2
        settle("press2", 4'b0110);
        settle("rel2", 4'b0010);
        buttons = 4'b0110;
        tick(1 + D);
        bus_write(32'h4, 32'h6, 4'b0001, 1'b1);
        m_events = m_events & ~32'h6;
        model_levels(4'b0110);
        push_regs("w1c_race");
        drain();
        tick(1);
        check("w1c_race_pend", 32'(event_pending), 32'(|m_events));

        // COUNT wrap 0xFFFF -> 0x0000
        settle("relall", 4'b0000);
        force dut.count_reg = 16'hFFFF;
        #1;
        release dut.count_reg;
        m_count = 16'hFFFF;
        push("preload_count", 32'h8, 32'h0000_FFFF);
        drain();
        settle("wrap", 4'b0001);

        // COUNT clear by any nonzero mask
        force dut.count_reg = 16'd5;
        #1;
        release dut.count_reg;
        bus_write(32'h8, 32'h0, 4'b1000, 1'b1);
        m_count = 16'd0;
        push_regs("cnt_clr");
        drain();

        // Two presses in one cycle from COUNT=5
        settle("rel_b", 4'b0000);
        bus_write(32'h4, 32'hFFFF_FFFF, 4'hF, 1'b1);
        m_events = m_events & ~expand(4'hF);
        force dut.count_reg = 16'd5;
        #1;
        release dut.count_reg;
        m_count = 16'd5;
        settle("dual", 4'b1001);

        // Press in the same cycle as a COUNT clear
        settle("rel_c", 4'b0000);
        buttons = 4'b0110;
        tick(1 + D);
        bus_write(32'h8, 32'h0, 4'b0001, 1'b1);
        m_count = 16'd0;
        model_levels(4'b0110);
        push_regs("clr_race");
        drain();

        // Reserved offset reads 0; writes to reserved/RO registers ignored
        push("resv", 32'hC, 32'h0);
        bus_write(32'hC, 32'hFFFF_FFFF, 4'hF, 1'b1);
        bus_write(32'h0, 32'hFFFF_FFFF, 4'hF, 1'b1);
        push_regs("ro_wr");
        drain();

        // Deselected: read data and ready both zero
        bus.sel_in = 1'b0; bus.read_in = 1'b1; bus.address_in = 32'h4;
        #1;
        check("desel_rdata", bus.read_value_out, 32'h0);
        check("desel_ready", 32'(bus.ready_out), 32'h0);
        bus.read_in = 1'b0;

        // Reset while button 2's debounce counter sits at D-1
        settle("rel_d", 4'b0000);
        buttons = 4'b0100;
        tick(1 + D);
        reset = 1'b1;
        #1;
        m_state = '0; m_events = '0; m_count = '0;
        push_regs("rst_mid");
        drain();
        check("rst_mid_pend", 32'(event_pending), 32'd0);
        tick(3);
        push_regs("rst_hold");
        drain();
        reset = 1'b0;
        tick(1 + D);
        bus_read("post_rst5", 32'h0, v); check("post_rst5_state", v, 32'h0);
        tick(1);
        model_levels(4'b0100);
        push_regs("post_rst");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
